// File: rtl/ram_arbiter_if.sv
// Host loader port of the RAM arbiter: ownership request/grant plus a
// valid/ready access stream with read-data return.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 12
) ();
    logic          host_req;
    logic          host_gnt;
    logic          host_addr_ld;
    logic [AW-1:0] host_addr;
    logic          host_valid;
    logic          host_we;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    modport master (
        output host_req,
        output host_addr_ld,
        output host_addr,
        output host_valid,
        output host_we,
        output host_wdata,
        input  host_gnt,
        input  host_ready,
        input  host_rdata,
        input  host_rvalid
    );

    modport slave (
        input  host_req,
        input  host_addr_ld,
        input  host_addr,
        input  host_valid,
        input  host_we,
        input  host_wdata,
        output host_gnt,
        output host_ready,
        output host_rdata,
        output host_rvalid
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the program/data RAM port between the CPU datapath and the host loader,
// handing over only at instruction boundaries. Option: RAM_ARBITER_WRITE_PROTECT_EN.
module ram_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 12,
    parameter int PROT_LIMIT = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_ce,
    input  logic          cpu_boundary,
    output logic          cpu_hold,
    ram_arbiter_if.slave  host,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_ce,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
    ,
    output logic          cpu_wp_fault
`endif
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOST    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [AW:0]   PROT_LIMIT_W = (AW+1)'(PROT_LIMIT);
    localparam logic [AW-1:0] ADDR_ONE     = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic          hold_r;
    logic          gnt_r;
    logic [AW-1:0] ptr_r;
    logic [DW-1:0] rdata_r;
    logic          rvalid_r;

    logic          host_ready_s;
    logic          acc_s;
    logic          acc_wr_s;
    logic          acc_rd_s;
    logic [AW-1:0] eff_addr_s;
    logic          cpu_owns_s;
    logic          prot_hit_s;

`ifdef RAM_ARBITER_WRITE_PROTECT_EN
    logic          fault_r;

    assign cpu_wp_fault = fault_r;
`else
    logic          unused_prot_s;

    assign unused_prot_s = ^PROT_LIMIT_W;
`endif

    assign cpu_hold         = hold_r;
    assign host.host_gnt    = gnt_r;
    assign host.host_ready  = host_ready_s;
    assign host.host_rdata  = rdata_r;
    assign host.host_rvalid = rvalid_r;

    // Host beat acceptance, effective address and CPU write-protect decode
    always_comb begin
        cpu_owns_s   = (state_r == ST_CPU) || (state_r == ST_DRAIN);
        // A dropped request blocks acceptance in the final HOST cycle
        host_ready_s = (state_r == ST_HOST) && host.host_req;
        acc_s        = host_ready_s && host.host_valid;
        acc_wr_s     = acc_s && host.host_we;
        acc_rd_s     = acc_s && !host.host_we;
        if (host.host_addr_ld) begin
            eff_addr_s = host.host_addr;
        end else begin
            eff_addr_s = ptr_r;
        end
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
        prot_hit_s = cpu_owns_s && cpu_we && ({1'b0, cpu_addr} < PROT_LIMIT_W);
`else
        prot_hit_s = 1'b0;
`endif
    end

    // RAM port steering by owner
    always_comb begin
        ram_addr  = ptr_r;
        ram_wdata = {DW{1'b0}};
        ram_we    = 1'b0;
        ram_ce    = 1'b0;
        case (state_r)
            ST_CPU, ST_DRAIN: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we && !prot_hit_s;
                ram_ce    = cpu_ce;
            end
            ST_HOST: begin
                ram_addr  = eff_addr_s;
                ram_wdata = host.host_wdata;
                ram_we    = acc_wr_s;
                ram_ce    = acc_rd_s;
            end
            ST_RELEASE: begin
                ram_addr  = ptr_r;
                ram_wdata = {DW{1'b0}};
                ram_we    = 1'b0;
                ram_ce    = 1'b0;
            end
            default: begin
                ram_addr  = ptr_r;
                ram_wdata = {DW{1'b0}};
                ram_we    = 1'b0;
                ram_ce    = 1'b0;
            end
        endcase
    end

    // Ownership FSM with registered hold/grant, host pointer and read return
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r  <= ST_CPU;
            hold_r   <= 1'b0;
            gnt_r    <= 1'b0;
            ptr_r    <= {AW{1'b0}};
            rdata_r  <= {DW{1'b0}};
            rvalid_r <= 1'b0;
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
            fault_r  <= 1'b0;
`endif
        end else begin
            rvalid_r <= acc_rd_s;
            if (acc_rd_s) begin
                rdata_r <= ram_rdata;
            end else begin
                rdata_r <= rdata_r;
            end

            if (acc_s) begin
                ptr_r <= eff_addr_s + ADDR_ONE;
            end else if (host_ready_s && host.host_addr_ld) begin
                ptr_r <= host.host_addr;
            end else begin
                ptr_r <= ptr_r;
            end

`ifdef RAM_ARBITER_WRITE_PROTECT_EN
            fault_r <= fault_r || prot_hit_s;
`endif

            case (state_r)
                ST_CPU: begin
                    hold_r <= 1'b0;
                    gnt_r  <= 1'b0;
                    if (host.host_req) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_CPU;
                    end
                end
                ST_DRAIN: begin
                    if (!host.host_req) begin
                        state_r <= ST_CPU;
                    end else if (cpu_boundary) begin
                        state_r <= ST_HOST;
                        hold_r  <= 1'b1;
                        gnt_r   <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_HOST: begin
                    if (!host.host_req) begin
                        state_r <= ST_RELEASE;
                        gnt_r   <= 1'b0;
                    end else begin
                        state_r <= ST_HOST;
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_CPU;
                    hold_r  <= 1'b0;
                    gnt_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_CPU;
                    hold_r  <= 1'b0;
                    gnt_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a cycle table through grant/transfer/release,
// then hand sequences for reset mid-burst and the optional write protect.
module tb_ram_arbiter;

    logic        clk;
    logic        clr;
    logic [7:0]  cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_ce;
    logic        cpu_boundary;
    logic        cpu_hold;
    logic [7:0]  ram_addr;
    logic [11:0] ram_wdata;
    logic        ram_we;
    logic        ram_ce;
    logic [11:0] ram_rdata;
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
    logic        cpu_wp_fault;
`endif

    ram_arbiter_if #(.AW(8), .DW(12)) hif ();

    ram_arbiter #(.AW(8), .DW(12), .PROT_LIMIT(16)) dut (
        .clk          (clk),
        .clr          (clr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .cpu_ce       (cpu_ce),
        .cpu_boundary (cpu_boundary),
        .cpu_hold     (cpu_hold),
        .host         (hif),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_ce       (ram_ce),
        .ram_rdata    (ram_rdata)
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
        ,
        .cpu_wp_fault (cpu_wp_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, posedge write
    logic [11:0] mem [0:255];
    logic        mem_clear;
    int          we_cnt;
    logic        we_cnt_en;

    assign ram_rdata = ram_ce ? mem[ram_addr] : 12'h000;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < 256; k++) mem[k] <= 12'h000;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (we_cnt_en && ram_we) we_cnt <= we_cnt + 1;
    end

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  c_addr;
        logic [11:0] c_wdata;
        logic        c_we;
        logic        c_ce;
        logic        c_bnd;
        logic        h_req;
        logic        h_ld;
        logic [7:0]  h_addr;
        logic        h_valid;
        logic        h_we;
        logic [11:0] h_wdata;
        logic        e_hold;
        logic        e_gnt;
        logic        e_ready;
        logic        e_we;
        logic        e_ce;
        logic        e_addr_chk;
        logic [7:0]  e_addr;
        logic        e_rvalid;
        logic [11:0] e_rdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic drive(input vec_t v);
        cpu_addr         = v.c_addr;
        cpu_wdata        = v.c_wdata;
        cpu_we           = v.c_we;
        cpu_ce           = v.c_ce;
        cpu_boundary     = v.c_bnd;
        hif.host_req     = v.h_req;
        hif.host_addr_ld = v.h_ld;
        hif.host_addr    = v.h_addr;
        hif.host_valid   = v.h_valid;
        hif.host_we      = v.h_we;
        hif.host_wdata   = v.h_wdata;
    endtask

    task automatic cpu_idle();
        cpu_addr = 8'h33; cpu_wdata = 12'h000; cpu_we = 1'b0; cpu_ce = 1'b0; cpu_boundary = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        we_cnt = 0;
        we_cnt_en = 1'b0;
        mem_clear = 1'b1;
        clr = 1'b0;
        cpu_idle();
        hif.host_req = 1'b0; hif.host_addr_ld = 1'b0; hif.host_addr = 8'h00;
        hif.host_valid = 1'b0; hif.host_we = 1'b0; hif.host_wdata = 12'h000;

        //           caddr  cwdata   we    ce    bnd   req   ld    haddr  val   hwe   hwdata   hold  gnt   rdy   rwe   rce   achk  eaddr  rvld  rdata
        vecs[0]  = '{8'h20, 12'h5A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 12'h000};
        vecs[1]  = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h000};
        vecs[2]  = '{8'h20, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 12'h000};
        vecs[3]  = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h000};
        vecs[4]  = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h000};
        vecs[5]  = '{8'h40, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 12'h000};
        vecs[6]  = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 12'h111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 12'h000};
        vecs[7]  = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 12'h222, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 12'h000};
        vecs[8]  = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 12'h333, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 12'h000};
        vecs[9]  = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 12'h000};
        vecs[10] = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 12'h000};
        vecs[11] = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 12'h111};
        vecs[12] = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 12'h222};
        vecs[13] = '{8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 12'h333};
        vecs[14] = '{8'h21, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h333};
        vecs[15] = '{8'h20, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 12'h333};
        vecs[16] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};
        vecs[17] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};
        vecs[18] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h333};
        vecs[19] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h333};
        vecs[20] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};
        vecs[21] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};
        vecs[22] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};
        vecs[23] = '{8'h33, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 12'h333};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_hold",   32'(cpu_hold),         32'd0);
        chk("rst_gnt",    32'(hif.host_gnt),     32'd0);
        chk("rst_ready",  32'(hif.host_ready),   32'd0);
        chk("rst_rvalid", 32'(hif.host_rvalid),  32'd0);
        chk("rst_rdata",  32'(hif.host_rdata),   32'd0);
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
        chk("rst_fault",  32'(cpu_wp_fault),     32'd0);
`endif
        @(negedge clk);
        mem_clear = 1'b0;
        clr = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_hold", i),   32'(cpu_hold),        32'(vecs[i].e_hold));
            chk($sformatf("v%0d_gnt", i),    32'(hif.host_gnt),    32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_ready", i),  32'(hif.host_ready),  32'(vecs[i].e_ready));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we),          32'(vecs[i].e_we));
            chk($sformatf("v%0d_ram_ce", i), 32'(ram_ce),          32'(vecs[i].e_ce));
            chk($sformatf("v%0d_rvalid", i), 32'(hif.host_rvalid), 32'(vecs[i].e_rvalid));
            chk($sformatf("v%0d_rdata", i),  32'(hif.host_rdata),  32'(vecs[i].e_rdata));
            if (vecs[i].e_addr_chk) begin
                chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            end
        end

        @(negedge clk);
        cpu_idle();
        chk("mem_20", 32'(mem[8'h20]), 32'h5A5);
        chk("mem_fe", 32'(mem[8'hFE]), 32'h111);
        chk("mem_ff", 32'(mem[8'hFF]), 32'h222);
        chk("mem_00", 32'(mem[8'h00]), 32'h333);
        chk("mem_21_release_blocked", 32'(mem[8'h21]), 32'h000);
        chk("mem_40_cpu_ignored",     32'(mem[8'h40]), 32'h000);

`ifdef RAM_ARBITER_WRITE_PROTECT_EN
        // Protected CPU write is suppressed and latches the fault
        cpu_addr = 8'h05; cpu_wdata = 12'h123; cpu_we = 1'b1;
        #1;
        chk("wp_05_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        chk("wp_fault_set", 32'(cpu_wp_fault), 32'd1);
        cpu_addr = 8'h10; cpu_wdata = 12'h456; cpu_we = 1'b1;
        #1;
        chk("wp_10_we", 32'(ram_we), 32'd1);
        @(negedge clk);
        cpu_idle();
        chk("wp_fault_sticky", 32'(cpu_wp_fault), 32'd1);
        chk("wp_mem_05", 32'(mem[8'h05]), 32'h000);
        chk("wp_mem_10", 32'(mem[8'h10]), 32'h456);
`endif

        // Reset in the middle of a host write burst
        hif.host_req = 1'b1; cpu_boundary = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("burst_gnt", 32'(hif.host_gnt), 32'd1);
        hif.host_addr_ld = 1'b1; hif.host_addr = 8'h80;
        hif.host_valid = 1'b1; hif.host_we = 1'b1; hif.host_wdata = 12'hAAA;
        #1;
        chk("burst_we0", 32'(ram_we), 32'd1);
        chk("burst_addr0", 32'(ram_addr), 32'h80);
        @(negedge clk);
        hif.host_addr_ld = 1'b0; hif.host_wdata = 12'hBBB;
        #1;
        chk("burst_addr1", 32'(ram_addr), 32'h81);
        #2;
        clr = 1'b0;
        we_cnt_en = 1'b1;
        #1;
        chk("clr_hold",   32'(cpu_hold),        32'd0);
        chk("clr_gnt",    32'(hif.host_gnt),    32'd0);
        chk("clr_ready",  32'(hif.host_ready),  32'd0);
        chk("clr_rvalid", 32'(hif.host_rvalid), 32'd0);
        chk("clr_rdata",  32'(hif.host_rdata),  32'd0);
        chk("clr_ram_we", 32'(ram_we),          32'd0);
`ifdef RAM_ARBITER_WRITE_PROTECT_EN
        chk("clr_fault",  32'(cpu_wp_fault),    32'd0);
`endif
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        we_cnt_en = 1'b0;
        chk("clr_no_writes", 32'(we_cnt), 32'd0);
        chk("mem_80", 32'(mem[8'h80]), 32'hAAA);
        chk("mem_81_aborted", 32'(mem[8'h81]), 32'h000);
        // Back in HOST: pointer restarted from zero
        chk("post_gnt", 32'(hif.host_gnt), 32'd1);
        hif.host_wdata = 12'h777;
        #1;
        chk("post_ptr_addr", 32'(ram_addr), 32'h00);
        chk("post_we", 32'(ram_we), 32'd1);
        @(negedge clk);
        hif.host_req = 1'b0; hif.host_valid = 1'b0; hif.host_we = 1'b0; cpu_boundary = 1'b0;
        chk("mem_00_post", 32'(mem[8'h00]), 32'h777);
        repeat (3) @(negedge clk);
        chk("final_hold", 32'(cpu_hold), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
